// File: rtl/sram_sp_ctrl.sv
// Single-port SRAM with valid/ready requests, masked writes, post-reset clearing
// and an in-order, backpressure-safe read response path.
module sram_sp_ctrl #(
  parameter int DATA_WIDTH     = 32,
  parameter int DEPTH          = 1024,
  parameter int MASK_GRAN      = 8,
  parameter int OUT_REG        = 0,
  parameter int CLEAR_ON_RESET = 1,
  localparam int ADDR_WIDTH    = $clog2(DEPTH),
  localparam int MASK_WIDTH    = DATA_WIDTH / MASK_GRAN
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [MASK_WIDTH-1:0] req_wmask,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  init_busy
);

  localparam int RSP_DEPTH = 2 + OUT_REG;
  localparam int CNT_W     = $clog2(RSP_DEPTH + 1);
  localparam int PTR_W     = $clog2(RSP_DEPTH);

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;

  if ((DATA_WIDTH % MASK_GRAN) != 0 || DEPTH < 2 || (OUT_REG != 0 && OUT_REG != 1)) begin : g_bad_params
    $error("sram_sp_ctrl: illegal parameter combination");
  end

  logic [0:0]            state_reg;
  logic [ADDR_WIDTH-1:0] clear_addr_reg;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  accept;
  logic                  addr_ok;
  logic                  rd_en;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [MASK_WIDTH-1:0] wr_mask;
  logic [MASK_WIDTH-1:0] lane_we;

  logic [DATA_WIDTH-1:0] rd_data_reg;
  logic                  s1_valid_reg;
  logic                  s1_err_reg;
  logic [DATA_WIDTH-1:0] s1_data;

  logic                  last_valid;
  logic                  last_err;
  logic [DATA_WIDTH-1:0] last_data;
  logic [CNT_W-1:0]      pipe_cnt;

  logic [DATA_WIDTH-1:0] fifo_data_reg [RSP_DEPTH];
  logic                  fifo_err_reg  [RSP_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_reg;
  logic [PTR_W-1:0]      rd_ptr_reg;
  logic [CNT_W-1:0]      count_reg;
  logic                  fifo_empty;
  logic                  push;
  logic                  pop;
  logic                  credit_ok;

  assign addr_ok = {1'b0, req_addr} < (ADDR_WIDTH + 1)'(DEPTH);
  assign accept  = req_valid && req_ready;
  assign rd_en   = accept && !req_we;

  // Credits count every read not yet handed out, so the FIFO can absorb all of them.
  assign credit_ok = ({1'b0, count_reg} + {1'b0, pipe_cnt}) < (CNT_W + 1)'(RSP_DEPTH);
  assign req_ready = rst_n && (state_reg == ST_RUN) && credit_ok;
  assign init_busy = (state_reg == ST_CLEAR);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg      <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
      clear_addr_reg <= '0;
    end else if (state_reg == ST_CLEAR) begin
      if (clear_addr_reg == ADDR_WIDTH'(DEPTH - 1)) begin
        state_reg <= ST_RUN;
      end else begin
        clear_addr_reg <= clear_addr_reg + 1'b1;
      end
    end
  end

  // The clear sequence and request writes share the single write port.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = req_addr;
    wr_data = req_wdata;
    wr_mask = req_wmask;
    if (state_reg == ST_CLEAR) begin
      wr_en   = 1'b1;
      wr_addr = clear_addr_reg;
      wr_data = '0;
      wr_mask = '1;
    end else if (accept && req_we && addr_ok) begin
      wr_en = 1'b1;
    end
  end

  for (genvar gi = 0; gi < MASK_WIDTH; gi++) begin : g_lane
    assign lane_we[gi] = wr_en && wr_mask[gi];
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < MASK_WIDTH; i++) begin
        if (lane_we[i]) begin
          mem[wr_addr][i*MASK_GRAN +: MASK_GRAN] <= wr_data[i*MASK_GRAN +: MASK_GRAN];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rd_en && addr_ok) begin
      rd_data_reg <= mem[req_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_reg <= 1'b0;
      s1_err_reg   <= 1'b0;
    end else begin
      s1_valid_reg <= rd_en;
      s1_err_reg   <= rd_en && !addr_ok;
    end
  end

  // Out-of-range reads never touch the array; their data is forced to zero here.
  assign s1_data = s1_err_reg ? '0 : rd_data_reg;

  if (OUT_REG != 0) begin : g_out_reg
    logic                  s2_valid_reg;
    logic                  s2_err_reg;
    logic [DATA_WIDTH-1:0] s2_data_reg;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        s2_valid_reg <= 1'b0;
        s2_err_reg   <= 1'b0;
        s2_data_reg  <= '0;
      end else begin
        s2_valid_reg <= s1_valid_reg;
        s2_err_reg   <= s1_err_reg;
        s2_data_reg  <= s1_data;
      end
    end

    assign last_valid = s2_valid_reg;
    assign last_err   = s2_err_reg;
    assign last_data  = s2_data_reg;
    assign pipe_cnt   = CNT_W'(s1_valid_reg) + CNT_W'(s2_valid_reg);
  end else begin : g_no_out_reg
    assign last_valid = s1_valid_reg;
    assign last_err   = s1_err_reg;
    assign last_data  = s1_data;
    assign pipe_cnt   = CNT_W'(s1_valid_reg);
  end

  // The final pipe stage bypasses an empty FIFO; anything not consumed is queued.
  assign fifo_empty = (count_reg == '0);
  assign pop        = !fifo_empty && rsp_ready;
  assign push       = last_valid && !(fifo_empty && rsp_ready);

  assign rsp_valid = !fifo_empty || last_valid;
  assign rsp_rdata = !fifo_empty ? fifo_data_reg[rd_ptr_reg] : (last_valid ? last_data : '0);
  assign rsp_err   = !fifo_empty ? fifo_err_reg[rd_ptr_reg]  : (last_valid && last_err);

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data_reg[wr_ptr_reg] <= last_data;
      fifo_err_reg[wr_ptr_reg]  <= last_err;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= (wr_ptr_reg == PTR_W'(RSP_DEPTH - 1)) ? '0 : wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= (rd_ptr_reg == PTR_W'(RSP_DEPTH - 1)) ? '0 : rd_ptr_reg + 1'b1;
      end
      count_reg <= count_reg + CNT_W'(push) - CNT_W'(pop);
    end
  end

endmodule
